// File: rtl/riscv_core_dcache_nway.sv
// N-way set-associative L1 data cache: write-through, no-write-allocate,
// per-set round-robin replacement, single-request stall interface to the core.
// Optional hit/miss counters are enabled by defining RISCV_DCACHE_PERF_CNT_EN.
module riscv_core_dcache_nway #(
  parameter int WAYS            = 2,
  parameter int INDEX_WIDTH     = 7,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH  = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [CORE_DATA_WIDTH-1:0] i_data_from_core,
  input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
  input  logic                       i_read,
  input  logic                       i_write,
  input  logic [1:0]                 i_size,
  output logic                       o_stall,
  output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
  output logic                       o_store_fault,
  output logic                       o_load_fault,
  output logic                       o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]      o_mem_read_address,
  input  logic                       i_mem_read_done,
  input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi,
  output logic                       o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]      o_mem_write_address,
  output logic [CORE_DATA_WIDTH-1:0] o_mem_write_data,
  output logic [7:0]                 o_mem_write_strobe,
  input  logic                       i_mem_write_done
`ifdef RISCV_DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                o_hit_count,
  output logic [31:0]                o_miss_count
`endif
);

  localparam int SETS      = 2 ** INDEX_WIDTH;
  localparam int OFFSET_W  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_W;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BYTES     = CORE_DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_t;

  state_t                        state_q;
  logic [WAYS-1:0][SETS-1:0]     valid_q;
  logic [SETS-1:0][WAY_W-1:0]    rr_ptr_q;
  logic [WAY_W-1:0]              victim_q;
  logic                          use_rr_q;
  logic [TAG_WIDTH-1:0]          tag_mem  [WAYS][SETS];
  logic [AXI_DATA_WIDTH-1:0]     data_mem [WAYS][SETS];

  logic [INDEX_WIDTH-1:0]        set_idx;
  logic [TAG_WIDTH-1:0]          tag;
  logic [OFFSET_W-4:0]           word_sel;
  logic [2:0]                    byte_off;
  logic [2:0]                    align_mask;
  logic [7:0]                    size_mask;
  logic                          misaligned, is_load, is_store, in_idle;
  logic                          load_ok, store_ok, read_hit, read_miss;
  logic [WAYS-1:0]               hit_vec;
  logic                          hit, has_invalid;
  logic [WAY_W-1:0]              hit_way, victim, rr_cur, rr_next;
  logic [AXI_DATA_WIDTH-1:0]     hit_line;
  logic [CORE_DATA_WIDTH-1:0]    load_word, load_shift, load_data;

  assign set_idx  = i_addr_from_core[OFFSET_W +: INDEX_WIDTH];
  assign tag      = i_addr_from_core[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign word_sel = i_addr_from_core[OFFSET_W-1:3];
  assign byte_off = i_addr_from_core[2:0];

  // Request decode; a simultaneous read and write is a store only.
  always_comb begin
    size_mask = 8'h01;
    unique case (i_size)
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
    align_mask = 3'((4'd1 << i_size) - 4'd1);
    misaligned = |(byte_off & align_mask);
    is_store   = i_write;
    is_load    = i_read & ~i_write;
    in_idle    = (state_q == StIdle);
    load_ok    = in_idle & is_load & ~misaligned;
    store_ok   = in_idle & is_store & ~misaligned;
  end

  // Tag lookup across all ways, plus victim choice: lowest invalid way, else rr pointer.
  always_comb begin
    hit_way     = '0;
    hit_line    = '0;
    victim      = rr_ptr_q[set_idx];
    has_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][set_idx] && (tag_mem[w][set_idx] == tag);
      if (hit_vec[w]) begin
        hit_way  = WAY_W'(w);
        hit_line = data_mem[w][set_idx];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][set_idx]) begin
        victim      = WAY_W'(w);
        has_invalid = 1'b1;
      end
    end
    hit       = |hit_vec;
    read_hit  = load_ok & hit;
    read_miss = load_ok & ~hit;
    rr_cur    = rr_ptr_q[set_idx];
    rr_next   = (rr_cur == WAY_W'(WAYS - 1)) ? '0 : rr_cur + WAY_W'(1);
  end

  // Load path: pick the 64-bit word, right-align the addressed bytes, zero-extend.
  always_comb begin
    load_word  = hit_line[word_sel * CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
    load_shift = load_word >> {byte_off, 3'b000};
    unique case (i_size)
      2'd0: load_data = 64'(load_shift[7:0]);
      2'd1: load_data = 64'(load_shift[15:0]);
      2'd2: load_data = 64'(load_shift[31:0]);
      default: load_data = load_shift;
    endcase
    o_data_to_core = read_hit ? load_data : '0;
  end

  // Core-side status; gated by reset so nothing is signalled while held in reset.
  always_comb begin
    o_load_fault  = i_rst_n & in_idle & is_load & misaligned;
    o_store_fault = i_rst_n & in_idle & is_store & misaligned;
    unique case (state_q)
      StIdle:   o_stall = read_miss | store_ok;
      StRefill: o_stall = 1'b1;
      StWrite:  o_stall = ~i_mem_write_done;
      default:  o_stall = 1'b0;
    endcase
    o_stall = o_stall & i_rst_n;
  end

  // Control FSM with registered memory-side outputs, valid bits and rr pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q             <= StIdle;
      valid_q             <= '0;
      rr_ptr_q            <= '0;
      victim_q            <= '0;
      use_rr_q            <= 1'b0;
      o_mem_read_req      <= 1'b0;
      o_mem_read_address  <= '0;
      o_mem_write_valid   <= 1'b0;
      o_mem_write_address <= '0;
      o_mem_write_data    <= '0;
      o_mem_write_strobe  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (store_ok) begin
            state_q             <= StWrite;
            o_mem_write_valid   <= 1'b1;
            o_mem_write_address <= {i_addr_from_core[ADDR_WIDTH-1:3], 3'b000};
            o_mem_write_data    <= i_data_from_core << {byte_off, 3'b000};
            o_mem_write_strobe  <= size_mask << byte_off;
          end else if (read_miss) begin
            state_q            <= StRefill;
            o_mem_read_req     <= 1'b1;
            o_mem_read_address <= {i_addr_from_core[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            victim_q           <= victim;
            use_rr_q           <= ~has_invalid;
          end
        end
        StRefill: begin
          if (i_mem_read_done) begin
            valid_q[victim_q][set_idx] <= 1'b1;
            if (use_rr_q) rr_ptr_q[set_idx] <= rr_next;
            o_mem_read_req <= 1'b0;
            state_q        <= StIdle;
          end
        end
        StWrite: begin
          if (i_mem_write_done) begin
            o_mem_write_valid <= 1'b0;
            state_q           <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data arrays: line fill on refill, strobed merge on a write-through hit.
  always_ff @(posedge i_clk) begin
    if (state_q == StRefill && i_mem_read_done) begin
      data_mem[victim_q][set_idx] <= i_block_from_axi;
      tag_mem[victim_q][set_idx]  <= tag;
    end
    if (state_q == StWrite && i_mem_write_done && hit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (o_mem_write_strobe[b]) begin
          data_mem[hit_way][set_idx][(word_sel * BYTES + b) * 8 +: 8] <=
            o_mem_write_data[b * 8 +: 8];
        end
      end
    end
  end

`ifdef RISCV_DCACHE_PERF_CNT_EN
  // Hit/miss counters; both wrap naturally at 2**32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else begin
      if (read_hit)  o_hit_count  <= o_hit_count + 32'd1;
      if (read_miss) o_miss_count <= o_miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_core_dcache_nway.sv
// Directed bench for riscv_core_dcache_nway (WAYS=2, INDEX_WIDTH=7).
module tb_riscv_core_dcache_nway;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  data_from_core, addr_from_core, data_to_core;
  logic         rd, wr, stall, store_fault, load_fault;
  logic [1:0]   size;
  logic         mem_read_req, mem_read_done, mem_write_valid, mem_write_done;
  logic [63:0]  mem_read_address, mem_write_address, mem_write_data;
  logic [255:0] block_from_axi;
  logic [7:0]   mem_write_strobe;
`ifdef RISCV_DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_core_dcache_nway dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_data_from_core    (data_from_core),
    .i_addr_from_core    (addr_from_core),
    .i_read              (rd),
    .i_write             (wr),
    .i_size              (size),
    .o_stall             (stall),
    .o_data_to_core      (data_to_core),
    .o_store_fault       (store_fault),
    .o_load_fault        (load_fault),
    .o_mem_read_req      (mem_read_req),
    .o_mem_read_address  (mem_read_address),
    .i_mem_read_done     (mem_read_done),
    .i_block_from_axi    (block_from_axi),
    .o_mem_write_valid   (mem_write_valid),
    .o_mem_write_address (mem_write_address),
    .o_mem_write_data    (mem_write_data),
    .o_mem_write_strobe  (mem_write_strobe),
    .i_mem_write_done    (mem_write_done)
`ifdef RISCV_DCACHE_PERF_CNT_EN
    ,
    .o_hit_count         (hit_count),
    .o_miss_count        (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [7:0] base);
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input logic [63:0] a, input logic [1:0] s);
    rd = 1'b1; wr = 1'b0; addr_from_core = a; size = s;
    #1;
  endtask

  task automatic drive_write(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    rd = 1'b0; wr = 1'b1; addr_from_core = a; size = s; data_from_core = d;
    #1;
  endtask

  task automatic drop();
    rd = 1'b0; wr = 1'b0;
    #1;
  endtask

  task automatic serve_refill(input logic [255:0] line, input logic [63:0] exp_addr);
    int n = 0;
    while (mem_read_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("rd_req", mem_read_req, 1'b1);
    check("rd_addr", mem_read_address, exp_addr);
    check("rd_no_wv", mem_write_valid, 1'b0);
    check("rd_stall", stall, 1'b1);
    mem_read_done = 1'b1;
    block_from_axi = line;
    step();
    mem_read_done = 1'b0;
    #1;
  endtask

  task automatic serve_write(input logic [63:0] exp_addr, input logic [63:0] exp_data,
                             input logic [7:0] exp_strb);
    int n = 0;
    while (mem_write_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("wr_valid", mem_write_valid, 1'b1);
    check("wr_addr", mem_write_address, exp_addr);
    check("wr_data", mem_write_data, exp_data);
    check("wr_strb", mem_write_strobe, exp_strb);
    check("wr_no_rreq", mem_read_req, 1'b0);
    check("wr_stall", stall, 1'b1);
    mem_write_done = 1'b1;
    #1;
    check("wr_stall_done", stall, 1'b0);
    step();
    mem_write_done = 1'b0;
    drop();
  endtask

  task automatic check_hit(input string tag, input logic [63:0] a, input logic [1:0] s,
                           input logic [63:0] exp);
    drive_read(a, s);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_data"}, data_to_core, exp);
    step();
    check({tag, "_no_rreq"}, mem_read_req, 1'b0);
    drop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'd0;
    data_from_core = '0; addr_from_core = '0;
    mem_read_done = 1'b0; mem_write_done = 1'b0; block_from_axi = '0;
    repeat (3) step();
    check("rst_stall", stall, 1'b0);
    check("rst_rreq", mem_read_req, 1'b0);
    check("rst_wv", mem_write_valid, 1'b0);
    check("rst_faults", {load_fault, store_fault}, 2'b00);
    check("rst_data", data_to_core, 64'h0);
    check("rst_raddr", mem_read_address, 64'h0);
    check("rst_waddr", mem_write_address, 64'h0);
    check("rst_wdata", mem_write_data, 64'h0);
    check("rst_strb", mem_write_strobe, 8'h00);
`ifdef RISCV_DCACHE_PERF_CNT_EN
    check("rst_cnt", {hit_count, miss_count}, 64'h0);
`endif
    rst_n = 1'b1;
    step();

    // Cold miss and refill
    drive_read(64'h1000, 2'd3);
    check("cold_stall", stall, 1'b1);
    check("cold_no_data", data_to_core, 64'h0);
    serve_refill(mk_line(8'h00), 64'h1000);
    check("cold_hit_stall", stall, 1'b0);
    check("cold_data", data_to_core, 64'h0706050403020100);
    drop();

    // Store hit merges into the line
    drive_write(64'h1003, 2'd0, 64'hAB);
    check("st_stall", stall, 1'b1);
    serve_write(64'h1000, 64'hAB00_0000, 8'h08);
    check_hit("st_merge", 64'h1000, 2'd2, 64'hAB020100);

    // Other sizes/offsets from the same line
    check_hit("ld_d8", 64'h1008, 2'd3, 64'h0F0E0D0C0B0A0908);
    check_hit("ld_b5", 64'h1005, 2'd0, 64'h05);
    check_hit("ld_h6", 64'h1006, 2'd1, 64'h0706);
    check_hit("ld_w1c", 64'h101C, 2'd2, 64'h1F1E1D1C);

    // Misalignment faults
    drive_read(64'h1002, 2'd2);
    check("lf_fault", {load_fault, store_fault}, 2'b10);
    check("lf_stall", stall, 1'b0);
    step();
    check("lf_nomem", {mem_read_req, mem_write_valid}, 2'b00);
    drop();
    rd = 1'b1; wr = 1'b1; addr_from_core = 64'h1001; size = 2'd1;
    #1;
    check("sf_fault", {load_fault, store_fault}, 2'b01);
    check("sf_stall", stall, 1'b0);
    step();
    check("sf_nomem", {mem_read_req, mem_write_valid}, 2'b00);
    drop();

    // Conflicts in set 0 and round-robin eviction
    drive_read(64'h2000, 2'd3);
    serve_refill(mk_line(8'h40), 64'h2000);
    check("fill_2000", data_to_core, 64'h4746454443424140);
    drop();
    drive_read(64'h3000, 2'd3);
    serve_refill(mk_line(8'h80), 64'h3000);
    check("fill_3000", data_to_core, 64'h8786858483828180);
    drop();
    check_hit("rr_keep_2000", 64'h2000, 2'd3, 64'h4746454443424140);
    drive_read(64'h1000, 2'd3);
    check("rr_evict_1000", stall, 1'b1);
    serve_refill(mk_line(8'h00), 64'h1000);
    check("refill_1000", data_to_core, 64'h0706050403020100);
    drop();
    check_hit("rr_keep_3000", 64'h3000, 2'd3, 64'h8786858483828180);

    // Store miss: write-through only, no allocate
    drive_write(64'h9000, 2'd3, 64'h1122334455667788);
    serve_write(64'h9000, 64'h1122334455667788, 8'hFF);
    drive_read(64'h9000, 2'd3);
    check("nwa_miss", stall, 1'b1);
    serve_refill(mk_line(8'hC0), 64'h9000);
    check("fill_9000", data_to_core, 64'hC7C6C5C4C3C2C1C0);
    drop();
    check_hit("rr_keep_1000", 64'h1000, 2'd3, 64'h0706050403020100);

    // Reset in the middle of a refill
    drive_read(64'h5000, 2'd3);
    step();
    check("mid_rreq", mem_read_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rreq", mem_read_req, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_raddr", mem_read_address, 64'h0);
    check("mid_rst_data", data_to_core, 64'h0);
    step();
    rst_n = 1'b1;
    drop();
`ifdef RISCV_DCACHE_PERF_CNT_EN
    check("mid_rst_cnt", {hit_count, miss_count}, 64'h0);
`endif
    mem_read_done = 1'b1;
    block_from_axi = mk_line(8'h20);
    step();
    mem_read_done = 1'b0;
    #1;
    check("late_done_rreq", mem_read_req, 1'b0);
    check("late_done_stall", stall, 1'b0);
    drive_read(64'h1000, 2'd3);
    check("post_rst_miss", stall, 1'b1);
    serve_refill(mk_line(8'h00), 64'h1000);
    check("post_rst_data", data_to_core, 64'h0706050403020100);
    drop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
